dff_share_arb: RTL and testbench

DFF_SHARE_ARB -- requirements
Module: dff_share_arb

---
 rtl/dff_arb_pkg.sv | 21 ++
 rtl/rr_pick.sv | 36 +++
 rtl/dff_share_arb.sv | 142 ++++++++++++++
 tb/tb_dff_share_arb.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/dff_arb_pkg.sv
// Shared types and default constants for the dff_share_arb arbitrated register.
//   arb_state_e : FSM state encoding (IDLE, GRANT, HOLD)
//   DEF_*       : default parameter values for WIDTH, NREQ, HOLD_CYC
//   idx_width   : width needed to index n items (at least 1 bit)
package dff_arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        HOLD  = 2'd2
    } arb_state_e;

    localparam int unsigned DEF_WIDTH    = 8;
    localparam int unsigned DEF_NREQ     = 4;
    localparam int unsigned DEF_HOLD_CYC = 2;

    function automatic int unsigned idx_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker.
//   req    : request vector
//   ptr    : index where the search starts (ascending, wraps NREQ-1 -> 0)
//   winner : one-hot first asserted request found from ptr
//   idx    : binary index of winner
//   valid  : at least one request asserted
module rr_pick
    import dff_arb_pkg::*;
#(
    parameter int unsigned NREQ = DEF_NREQ,
    parameter int unsigned IDXW = idx_width(NREQ)
) (
    input  logic [NREQ-1:0] req,
    input  logic [IDXW-1:0] ptr,
    output logic [NREQ-1:0] winner,
    output logic [IDXW-1:0] idx,
    output logic            valid
);

    always_comb begin
        int unsigned k;
        k      = 0;
        winner = '0;
        idx    = '0;
        valid  = 1'b0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            k = (32'(ptr) + i) % NREQ;
            if (!valid && req[k]) begin
                valid     = 1'b1;
                winner[k] = 1'b1;
                idx       = IDXW'(k);
            end
        end
    end

endmodule

// File: rtl/dff_share_arb.sv
// Shared data register written by NREQ requesters under round-robin arbitration.
// A request sampled in IDLE is granted for one cycle; at the end of that cycle
// the winner's data slice is loaded into q and the winner is acked. The FSM then
// sits in HOLD for HOLD_CYC cycles before arbitrating again.
//   clk  : clock, rising edge
//   rst  : synchronous active-high reset
//   req  : per-requester level request, held until ack
//   din  : requester data, slice i = din[i*WIDTH +: WIDTH]
//   gnt  : registered one-hot grant (all-zero when idle)
//   ack  : registered one-cycle write-done pulse
//   q    : shared register contents
//   qbar : ~q
//   busy : high in GRANT and HOLD
module dff_share_arb
    import dff_arb_pkg::*;
#(
    parameter int unsigned WIDTH    = DEF_WIDTH,
    parameter int unsigned NREQ     = DEF_NREQ,
    parameter int unsigned HOLD_CYC = DEF_HOLD_CYC
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NREQ-1:0]       req,
    input  logic [NREQ*WIDTH-1:0] din,
    output logic [NREQ-1:0]       gnt,
    output logic [NREQ-1:0]       ack,
    output logic [WIDTH-1:0]      q,
    output logic [WIDTH-1:0]      qbar,
    output logic                  busy
);

    localparam int unsigned IDXW = idx_width(NREQ);
    localparam int unsigned CNTW = (HOLD_CYC > 0) ? $clog2(HOLD_CYC + 1) : 1;
    localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NREQ - 1);

    arb_state_e       state_q, state_d;
    logic [IDXW-1:0]  ptr_q, ptr_d;
    logic [CNTW-1:0]  hcnt_q, hcnt_d;
    logic [NREQ-1:0]  gnt_q, gnt_d;
    logic [NREQ-1:0]  ack_q, ack_d;
    logic [WIDTH-1:0] q_q, q_d;
    logic             busy_q, busy_d;

    logic [NREQ-1:0]  pick_oh;
    logic [IDXW-1:0]  pick_idx;
    logic             pick_vld;
    logic [WIDTH-1:0] sel_data;

    rr_pick #(
        .NREQ (NREQ),
        .IDXW (IDXW)
    ) u_rr_pick (
        .req    (req),
        .ptr    (ptr_q),
        .winner (pick_oh),
        .idx    (pick_idx),
        .valid  (pick_vld)
    );

    // gnt_q is the one-hot winner during GRANT, so it doubles as the data mux select.
    always_comb begin
        sel_data = '0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            if (gnt_q[i]) begin
                sel_data = din[i*WIDTH +: WIDTH];
            end
        end
    end

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        hcnt_d  = hcnt_q;
        gnt_d   = gnt_q;
        ack_d   = '0;
        q_d     = q_q;

        unique case (state_q)
            IDLE: begin
                gnt_d = '0;
                if (pick_vld) begin
                    state_d = GRANT;
                    gnt_d   = pick_oh;
                    ptr_d   = (pick_idx == LAST_IDX) ? '0 : pick_idx + IDXW'(1);
                end
            end
            GRANT: begin
                // Data is taken at the closing edge even if req has since dropped.
                q_d   = sel_data;
                ack_d = gnt_q;
                gnt_d = '0;
                if (HOLD_CYC > 0) begin
                    state_d = HOLD;
                    hcnt_d  = CNTW'(HOLD_CYC);
                end else begin
                    state_d = IDLE;
                end
            end
            HOLD: begin
                if (hcnt_q <= CNTW'(1)) begin
                    state_d = IDLE;
                    hcnt_d  = '0;
                end else begin
                    hcnt_d = hcnt_q - CNTW'(1);
                end
            end
            default: begin
                state_d = IDLE;
                gnt_d   = '0;
            end
        endcase

        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            hcnt_q  <= '0;
            gnt_q   <= '0;
            ack_q   <= '0;
            q_q     <= '0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            hcnt_q  <= hcnt_d;
            gnt_q   <= gnt_d;
            ack_q   <= ack_d;
            q_q     <= q_d;
            busy_q  <= busy_d;
        end
    end

    assign gnt  = gnt_q;
    assign ack  = ack_q;
    assign q    = q_q;
    assign qbar = ~q_q;
    assign busy = busy_q;

endmodule

// File: tb/tb_dff_share_arb.sv
// Directed bench for dff_share_arb: one instance with HOLD_CYC=2, one with HOLD_CYC=0.
module tb_dff_share_arb;

    localparam int W = 8;
    localparam int N = 4;

    logic           clk = 1'b0;
    logic           rst;
    logic [N-1:0]   req, req_z;
    logic [N*W-1:0] din, din_z;
    logic [N-1:0]   gnt, ack, gnt_z, ack_z;
    logic [W-1:0]   q, qbar, q_z, qbar_z;
    logic           busy, busy_z;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    dff_share_arb #(
        .WIDTH    (W),
        .NREQ     (N),
        .HOLD_CYC (2)
    ) dut (
        .clk  (clk),
        .rst  (rst),
        .req  (req),
        .din  (din),
        .gnt  (gnt),
        .ack  (ack),
        .q    (q),
        .qbar (qbar),
        .busy (busy)
    );

    dff_share_arb #(
        .WIDTH    (W),
        .NREQ     (N),
        .HOLD_CYC (0)
    ) dut_z (
        .clk  (clk),
        .rst  (rst),
        .req  (req_z),
        .din  (din_z),
        .gnt  (gnt_z),
        .ack  (ack_z),
        .q    (q_z),
        .qbar (qbar_z),
        .busy (busy_z)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic int oh2idx(input logic [N-1:0] oh);
        for (int i = 0; i < N; i++) if (oh[i]) return i;
        return -1;
    endfunction

    // Wait (bounded) for the HOLD_CYC=2 instance to return to IDLE.
    task automatic drain(input string tag);
        int i;
        i = 0;
        while (busy && i < 20) begin
            tick();
            i++;
        end
        check(tag, 32'(busy), 32'd0);
    endtask

    initial begin
        int idx_seen[$];
        int cyc_seen[$];
        logic [N-1:0] prev_gnt;
        int nk;

        rst   = 1'b1;
        req   = 4'b1111;
        req_z = 4'b0000;
        din   = '0;
        din_z = {8'h44, 8'h33, 8'h22, 8'h11};

        // Reset held two cycles with all requests up
        tick();
        tick();
        check("rst_gnt", 32'(gnt), 32'h0);
        check("rst_ack", 32'(ack), 32'h0);
        check("rst_q", 32'(q), 32'h00);
        check("rst_qbar", 32'(qbar), 32'hFF);
        check("rst_busy", 32'(busy), 32'h0);
        check("rst_q_z", 32'(q_z), 32'h00);
        rst = 1'b0;
        req = 4'b0000;
        tick();
        check("idle_gnt", 32'(gnt), 32'h0);

        // Single request on index 2
        din = {8'h00, 8'hA5, 8'h00, 8'h00};
        req = 4'b0100;
        tick();
        check("single_gnt", 32'(gnt), 32'h4);
        check("single_busy", 32'(busy), 32'h1);
        check("single_q_early", 32'(q), 32'h00);
        tick();
        req = 4'b0000;
        check("single_q", 32'(q), 32'hA5);
        check("single_qbar", 32'(qbar), 32'h5A);
        check("single_ack", 32'(ack), 32'h4);
        check("single_gnt_off", 32'(gnt), 32'h0);
        tick();
        check("single_ack_pulse", 32'(ack), 32'h0);
        check("single_q_hold", 32'(q), 32'hA5);
        tick();
        check("single_busy_end", 32'(busy), 32'h0);

        // All requests held from a fresh reset: rotation 0,1,2,3,0 spaced 4 cycles
        rst = 1'b1;
        tick();
        rst = 1'b0;
        din = {8'h44, 8'h33, 8'h22, 8'h11};
        req = 4'b1111;
        prev_gnt = '0;
        for (int c = 1; c <= 20; c++) begin
            tick();
            if (prev_gnt != 0) begin
                check("rr_ack", 32'(ack), 32'(prev_gnt));
                check("rr_q", 32'(q), 32'(8'h11 * (oh2idx(prev_gnt) + 1)));
            end
            if (gnt != 0) begin
                idx_seen.push_back(oh2idx(gnt));
                cyc_seen.push_back(c);
            end
            prev_gnt = gnt;
        end
        req = 4'b0000;
        check("rr_count", 32'(idx_seen.size() >= 5), 32'd1);
        nk = (idx_seen.size() < 5) ? idx_seen.size() : 5;
        for (int k = 0; k < nk; k++) begin
            check("rr_order", 32'(idx_seen[k]), 32'(k % 4));
            if (k > 0) check("rr_spacing", 32'(cyc_seen[k] - cyc_seen[k-1]), 32'd4);
        end
        drain("rr_drain");

        // Requester 0 drops req during GRANT; data sampled at the GRANT closing edge
        din = {8'h00, 8'h00, 8'h00, 8'h77};
        req = 4'b0001;
        tick();
        check("drop_gnt", 32'(gnt), 32'h1);
        req = 4'b0000;
        din = {8'h00, 8'h00, 8'h00, 8'h3C};
        tick();
        check("drop_q", 32'(q), 32'h3C);
        check("drop_ack", 32'(ack), 32'h1);
        drain("drop_drain");

        // Write FF from index 2 (ptr -> 3), then reset mid-HOLD
        din = {8'h00, 8'hFF, 8'h00, 8'h00};
        req = 4'b0100;
        tick();
        req = 4'b0000;
        tick();
        check("hold_q_ff", 32'(q), 32'hFF);
        tick();
        check("hold_busy", 32'(busy), 32'h1);
        rst = 1'b1;
        tick();
        check("midhold_q", 32'(q), 32'h00);
        check("midhold_qbar", 32'(qbar), 32'hFF);
        check("midhold_busy", 32'(busy), 32'h0);
        rst = 1'b0;
        req = 4'b1010;
        tick();
        check("midhold_ptr0", 32'(gnt), 32'h2);
        req = 4'b0000;
        tick();
        check("midhold_ack", 32'(ack), 32'h2);
        drain("midhold_drain");

        // Reset coinciding with the GRANT closing edge discards the write
        din = {8'h00, 8'h00, 8'h00, 8'h5A};
        req = 4'b0001;
        tick();
        check("rstgnt_gnt", 32'(gnt), 32'h1);
        rst = 1'b1;
        req = 4'b0000;
        tick();
        check("rstgnt_q", 32'(q), 32'h00);
        check("rstgnt_ack", 32'(ack), 32'h0);
        check("rstgnt_gnt_off", 32'(gnt), 32'h0);
        rst = 1'b0;

        // HOLD_CYC=0: back-to-back grants every 2 cycles, order 0,1,0,1
        idx_seen.delete();
        cyc_seen.delete();
        req_z = 4'b0011;
        for (int c = 1; c <= 8; c++) begin
            tick();
            if (gnt_z != 0) begin
                idx_seen.push_back(oh2idx(gnt_z));
                cyc_seen.push_back(c);
            end
        end
        req_z = 4'b0000;
        check("z_count", 32'(idx_seen.size()), 32'd4);
        nk = (idx_seen.size() < 4) ? idx_seen.size() : 4;
        for (int k = 0; k < nk; k++) begin
            check("z_order", 32'(idx_seen[k]), 32'(k % 2));
            if (k > 0) check("z_spacing", 32'(cyc_seen[k] - cyc_seen[k-1]), 32'd2);
        end
        tick();
        tick();
        check("z_q_last", 32'(q_z), 32'h22);
        check("z_busy_end", 32'(busy_z), 32'h0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
